cache_fill_arbiter: RTL and testbench
=====================================

Name: cache_fill_arbiter

Overview:
- Parametrised successor to the single-FSM I/D miss handler: one fill engine shared by NUM_CH caches (ch0 = I-cache, ch1 = D-cache by default) in front of one pipelined multicycle main memory.
- Arbitrates miss-fill and write-through requests with round-robin priority.
- Streams a BLOCK_WORDS line into the granted cache's data array with per-word write strobes, then pulses its tag write.
- Sits between the caches and memory4c-style memory in the CPU top level.

Parameters:
- NUM_CH, 2, number of requesting caches (1..8).
- ADDR_W, 16, byte-address width.
- DATA_W, 16, word width; words are DATA_W/8 bytes, power of 2.
- BLOCK_WORDS, 8, words per cache line; power of 2, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- miss_req  in  NUM_CH  per-channel miss, level, held until fill_done.
- miss_addr  in  NUM_CH*ADDR_W  per-channel miss byte address; ch i at [i*ADDR_W +: ADDR_W].
- wr_req  in  NUM_CH  per-channel write-through request, level, held until wr_ack.
- wr_addr  in  NUM_CH*ADDR_W  write-through byte addresses.
- wr_data  in  NUM_CH*DATA_W  write-through data.
- wr_ack  out  NUM_CH  one-cycle pulse when the channel's write is issued.
- grant  out  NUM_CH  one-hot; the channel currently served, 0 when idle.
- busy  out  1  engine not IDLE.
- fill_we  out  NUM_CH  data-array word write strobe, per channel.
- fill_tag_we  out  NUM_CH  tag/valid write strobe, per channel.
- fill_addr  out  ADDR_W  byte address of the word on fill_data; shared by all channels.
- fill_data  out  DATA_W  refill word; shared by all channels.
- fill_done  out  NUM_CH  one-cycle pulse when the channel's fill completes.
- mem_addr  out  ADDR_W  memory address.
- mem_enable  out  1  memory access strobe.
- mem_wr  out  1  1 = write, 0 = read.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_data_valid  in  1  mem_rdata valid; fixed but unknown latency; one valid per issued read, in order.

Behaviour:
- Reset: every output 0; state IDLE; rr pointer = ch0; issue and receive counters = 0. Reset mid-operation aborts at once. mem_data_valid pulses for reads still in flight are ignored after reset because the engine is in IDLE.
- States: IDLE, FILL, WRITE.
- IDLE: request vector req[i] = miss_req[i] | wr_req[i]. The round-robin arbiter picks the first set bit at or after the pointer, wrapping. On any request, register grant and move next cycle to WRITE if that channel's wr_req = 1, otherwise to FILL. Write-before-fill ordering within a channel guarantees the refetch sees the stored data.
- Latch base = miss_addr with the low log2(BLOCK_WORDS*DATA_W/8) bits cleared. Latch the write address and data at grant.
- FILL issue: for BLOCK_WORDS consecutive cycles drive mem_enable = 1, mem_wr = 0, mem_addr = base + issue_cnt*(DATA_W/8). The first issue is the cycle after grant. mem_enable = 0 after the last issue.
- FILL receive: on each mem_data_valid, drive in the same cycle (combinational) fill_we[g] = 1, fill_addr = base + rcv_cnt*(DATA_W/8), fill_data = mem_rdata; increment rcv_cnt.
- On the valid with rcv_cnt = BLOCK_WORDS-1, fill_tag_we[g] and fill_done[g] pulse with the last fill_we. Next cycle: IDLE, grant = 0, pointer = g+1 mod NUM_CH.
- Receive may overlap issue: a valid arriving during issue cycles is accepted.
- mem_data_valid is ignored in IDLE and WRITE.
- WRITE: one cycle with mem_enable = 1, mem_wr = 1, mem_addr and mem_wdata = the latched values, wr_ack[g] = 1. Next cycle: IDLE, pointer = g+1.
- After wr_ack, a still-pending miss_req on the same channel re-arbitrates normally; it is not a forced back-to-back grant.
- Dropping miss_req mid-fill does not abort the line; it completes.
- Requests arriving while busy wait; there is no pre-emption.
- fill_* and wr_ack are 0 for every channel other than g.
- Address arithmetic wraps modulo 2^ADDR_W.
- Idle to IDLE turnaround: 1 cycle.
- Fill occupancy: BLOCK_WORDS + memory latency + 1 cycles.

Decomposition:
- Package cache_fill_pkg holds:
  - state enum {IDLE, FILL, WRITE};
  - localparams WORD_BYTES, OFFSET_W = log2(BLOCK_WORDS*WORD_BYTES), CNT_W = log2(BLOCK_WORDS)+1;
  - a function for the block-base mask.
- One sub-module, rr_arbiter: NUM_CH requests plus pointer in, one-hot grant out, purely combinational.

Test Plan:
- Defaults, memory latency 4; ch1 miss_req at 0x1236 -> reads issued to 0x1230, 0x1232, …, 0x123E on 8 consecutive cycles. 8 fill_we[1] strobes with fill_addr 0x1230..0x123E in order. fill_tag_we[1] and fill_done[1] coincide with the 8th strobe. busy falls the cycle after.
- ch0 and ch1 miss in the same IDLE cycle after reset -> ch0 filled first, then ch1. Repeat both with the pointer now at ch1 -> ch1 served first.
- ch1 wr_req 0x0040/0xBEEF together with miss_req 0x0040 -> one mem_wr cycle at 0x0040 with data 0xBEEF and wr_ack[1]. The fill of 0x0040..0x004E follows and returns 0xBEEF at word 0.
- rst asserted on the 3rd receive of a fill, released; memory still delivers 5 valids -> no fill_we/fill_done during or after. Next miss to 0x2000 fills cleanly.
- Memory latency 1, BLOCK_WORDS = 2; miss_req dropped after grant -> both words and the tag still written. Address 0xFFFE with BLOCK_WORDS = 4 -> base 0xFFF8, no wrap error.
- NUM_CH = 4, all channels continuously requesting -> grants cycle 0, 1, 2, 3, 0. Only the granted channel's strobes ever assert.

Source files
------------

// File: rtl/cache_fill_pkg.sv
// Shared types and helpers for the cache fill arbiter: engine state encoding,
// default geometry and block-address arithmetic.
package cache_fill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_BLOCK_WORDS = 8;

  // Geometry of the default configuration.
  localparam int WORD_BYTES = DEF_DATA_W / 8;
  localparam int OFFSET_W   = $clog2(DEF_BLOCK_WORDS * WORD_BYTES);
  localparam int CNT_W      = $clog2(DEF_BLOCK_WORDS) + 1;

  function automatic int offset_bits(input int block_words, input int data_w);
    return $clog2(block_words * (data_w / 8));
  endfunction

  function automatic int count_bits(input int block_words);
    return $clog2(block_words) + 1;
  endfunction

  // Mask that clears the byte offset within a cache line.
  function automatic logic [31:0] block_mask(input int offset_w);
    return ~((32'd1 << offset_w) - 32'd1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping past the top channel.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int PTR_W  = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_CH);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shared fill engine: round-robin arbitration of cache miss fills and
// write-throughs onto one pipelined main memory.
module cache_fill_arbiter
  import cache_fill_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        miss_req,
  input  logic [NUM_CH*ADDR_W-1:0] miss_addr,
  input  logic [NUM_CH-1:0]        wr_req,
  input  logic [NUM_CH*ADDR_W-1:0] wr_addr,
  input  logic [NUM_CH*DATA_W-1:0] wr_data,
  output logic [NUM_CH-1:0]        wr_ack,
  output logic [NUM_CH-1:0]        grant,
  output logic                     busy,
  output logic [NUM_CH-1:0]        fill_we,
  output logic [NUM_CH-1:0]        fill_tag_we,
  output logic [ADDR_W-1:0]        fill_addr,
  output logic [DATA_W-1:0]        fill_data,
  output logic [NUM_CH-1:0]        fill_done,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_enable,
  output logic                     mem_wr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_data_valid
);

  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int OFF_W   = offset_bits(BLOCK_WORDS, DATA_W);
  localparam int CW      = count_bits(BLOCK_WORDS);
  localparam int PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W-1:0] BASE_MASK = ADDR_W'(block_mask(OFF_W));

  state_e              state, state_nx;
  logic [NUM_CH-1:0]   req, arb_gnt, grant_q;
  logic [PTR_W-1:0]    ptr, ptr_nx, g_idx;
  logic [CW-1:0]       issue_cnt, rcv_cnt;
  logic [ADDR_W-1:0]   base, wr_addr_q, sel_miss_addr, sel_wr_addr;
  logic [DATA_W-1:0]   wr_data_q, sel_wr_data;
  logic                sel_is_wr, issue_active, last_rcv;

  assign req = miss_req | wr_req;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt)
  );

  // Pick the winner's request fields and decode the active channel index.
  always_comb begin
    sel_miss_addr = '0;
    sel_wr_addr   = '0;
    sel_wr_data   = '0;
    g_idx         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_gnt[i]) begin
        sel_miss_addr = miss_addr[i*ADDR_W +: ADDR_W];
        sel_wr_addr   = wr_addr[i*ADDR_W +: ADDR_W];
        sel_wr_data   = wr_data[i*DATA_W +: DATA_W];
      end
      if (grant_q[i]) g_idx = PTR_W'(i);
    end
    sel_is_wr = |(arb_gnt & wr_req);
    ptr_nx    = (g_idx == PTR_W'(NUM_CH - 1)) ? '0 : g_idx + 1'b1;
  end

  assign issue_active = (state == FILL) && (issue_cnt < CW'(BLOCK_WORDS));
  assign last_rcv     = (state == FILL) && mem_data_valid &&
                        (rcv_cnt == CW'(BLOCK_WORDS - 1));
  assign grant        = grant_q;
  assign busy         = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q   <= '0;
      ptr       <= '0;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
      base      <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            grant_q   <= arb_gnt;
            base      <= sel_miss_addr & BASE_MASK;
            wr_addr_q <= sel_wr_addr;
            wr_data_q <= sel_wr_data;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
          end
        end
        FILL: begin
          if (issue_active)   issue_cnt <= issue_cnt + 1'b1;
          if (mem_data_valid) rcv_cnt   <= rcv_cnt + 1'b1;
          if (last_rcv) begin
            grant_q <= '0;
            ptr     <= ptr_nx;
          end
        end
        WRITE: begin
          grant_q <= '0;
          ptr     <= ptr_nx;
        end
        default: grant_q <= '0;
      endcase
    end
  end

  // Next state and memory/fill strobes; read data is forwarded the cycle it arrives.
  always_comb begin
    state_nx    = state;
    wr_ack      = '0;
    fill_we     = '0;
    fill_tag_we = '0;
    fill_done   = '0;
    fill_addr   = '0;
    fill_data   = '0;
    mem_addr    = '0;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_wdata   = '0;
    unique case (state)
      IDLE: begin
        if (|req) state_nx = sel_is_wr ? WRITE : FILL;
      end
      FILL: begin
        if (issue_active) begin
          mem_enable = 1'b1;
          mem_addr   = base + (ADDR_W'(issue_cnt) << BYTE_SH);
        end
        if (mem_data_valid) begin
          fill_we   = grant_q;
          fill_addr = base + (ADDR_W'(rcv_cnt) << BYTE_SH);
          fill_data = mem_rdata;
        end
        if (last_rcv) begin
          fill_tag_we = grant_q;
          fill_done   = grant_q;
          state_nx    = IDLE;
        end
      end
      WRITE: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = wr_addr_q;
        mem_wdata  = wr_data_q;
        wr_ack     = grant_q;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter: three configurations share one
// pipelined memory model; sel picks which instance is being exercised.
module tb_cache_fill_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int sel   = 0;
  int lat   = 4;

  // Instance A: defaults (2 channels, 8-word lines)
  logic [1:0]  miss_req_a = '0, wr_req_a = '0;
  logic [31:0] miss_addr_a = '0, wr_addr_a = '0, wr_data_a = '0;
  logic [1:0]  wr_ack_a, grant_a, fill_we_a, fill_tag_we_a, fill_done_a;
  logic        busy_a, mem_enable_a, mem_wr_a, valid_a;
  logic [15:0] fill_addr_a, fill_data_a, mem_addr_a, mem_wdata_a;
  // Instance B: 2 channels, 2-word lines
  logic [1:0]  miss_req_b = '0, wr_req_b = '0;
  logic [31:0] miss_addr_b = '0, wr_addr_b = '0, wr_data_b = '0;
  logic [1:0]  wr_ack_b, grant_b, fill_we_b, fill_tag_we_b, fill_done_b;
  logic        busy_b, mem_enable_b, mem_wr_b, valid_b;
  logic [15:0] fill_addr_b, fill_data_b, mem_addr_b, mem_wdata_b;
  // Instance C: 4 channels, 4-word lines
  logic [3:0]  miss_req_c = '0, wr_req_c = '0;
  logic [63:0] miss_addr_c = '0, wr_addr_c = '0, wr_data_c = '0;
  logic [3:0]  wr_ack_c, grant_c, fill_we_c, fill_tag_we_c, fill_done_c;
  logic        busy_c, mem_enable_c, mem_wr_c, valid_c;
  logic [15:0] fill_addr_c, fill_data_c, mem_addr_c, mem_wdata_c;

  logic [15:0] mrd;
  logic        mv;

  cache_fill_arbiter dut_a (
    .clk(clk), .rst(rst), .miss_req(miss_req_a), .miss_addr(miss_addr_a),
    .wr_req(wr_req_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_ack(wr_ack_a),
    .grant(grant_a), .busy(busy_a), .fill_we(fill_we_a), .fill_tag_we(fill_tag_we_a),
    .fill_addr(fill_addr_a), .fill_data(fill_data_a), .fill_done(fill_done_a),
    .mem_addr(mem_addr_a), .mem_enable(mem_enable_a), .mem_wr(mem_wr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mrd), .mem_data_valid(valid_a));

  cache_fill_arbiter #(.BLOCK_WORDS(2)) dut_b (
    .clk(clk), .rst(rst), .miss_req(miss_req_b), .miss_addr(miss_addr_b),
    .wr_req(wr_req_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_ack(wr_ack_b),
    .grant(grant_b), .busy(busy_b), .fill_we(fill_we_b), .fill_tag_we(fill_tag_we_b),
    .fill_addr(fill_addr_b), .fill_data(fill_data_b), .fill_done(fill_done_b),
    .mem_addr(mem_addr_b), .mem_enable(mem_enable_b), .mem_wr(mem_wr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mrd), .mem_data_valid(valid_b));

  cache_fill_arbiter #(.NUM_CH(4), .BLOCK_WORDS(4)) dut_c (
    .clk(clk), .rst(rst), .miss_req(miss_req_c), .miss_addr(miss_addr_c),
    .wr_req(wr_req_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c), .wr_ack(wr_ack_c),
    .grant(grant_c), .busy(busy_c), .fill_we(fill_we_c), .fill_tag_we(fill_tag_we_c),
    .fill_addr(fill_addr_c), .fill_data(fill_data_c), .fill_done(fill_done_c),
    .mem_addr(mem_addr_c), .mem_enable(mem_enable_c), .mem_wr(mem_wr_c),
    .mem_wdata(mem_wdata_c), .mem_rdata(mrd), .mem_data_valid(valid_c));

  // Outputs of the instance under test, widened to 4 channels
  logic [3:0]  m_grant, m_fill_we, m_tag_we, m_done, m_wr_ack;
  logic        m_busy, m_mem_en, m_mem_wr;
  logic [15:0] m_fill_addr, m_fill_data, m_mem_addr, m_mem_wdata;

  always_comb begin
    m_grant = '0; m_fill_we = '0; m_tag_we = '0; m_done = '0; m_wr_ack = '0;
    m_busy = 1'b0; m_mem_en = 1'b0; m_mem_wr = 1'b0;
    m_fill_addr = '0; m_fill_data = '0; m_mem_addr = '0; m_mem_wdata = '0;
    case (sel)
      0: begin
        m_grant = {2'b0, grant_a}; m_fill_we = {2'b0, fill_we_a};
        m_tag_we = {2'b0, fill_tag_we_a}; m_done = {2'b0, fill_done_a};
        m_wr_ack = {2'b0, wr_ack_a}; m_busy = busy_a; m_mem_en = mem_enable_a;
        m_mem_wr = mem_wr_a; m_fill_addr = fill_addr_a; m_fill_data = fill_data_a;
        m_mem_addr = mem_addr_a; m_mem_wdata = mem_wdata_a;
      end
      1: begin
        m_grant = {2'b0, grant_b}; m_fill_we = {2'b0, fill_we_b};
        m_tag_we = {2'b0, fill_tag_we_b}; m_done = {2'b0, fill_done_b};
        m_wr_ack = {2'b0, wr_ack_b}; m_busy = busy_b; m_mem_en = mem_enable_b;
        m_mem_wr = mem_wr_b; m_fill_addr = fill_addr_b; m_fill_data = fill_data_b;
        m_mem_addr = mem_addr_b; m_mem_wdata = mem_wdata_b;
      end
      default: begin
        m_grant = grant_c; m_fill_we = fill_we_c; m_tag_we = fill_tag_we_c;
        m_done = fill_done_c; m_wr_ack = wr_ack_c; m_busy = busy_c;
        m_mem_en = mem_enable_c; m_mem_wr = mem_wr_c; m_fill_addr = fill_addr_c;
        m_fill_data = fill_data_c; m_mem_addr = mem_addr_c; m_mem_wdata = mem_wdata_c;
      end
    endcase
  end

  // Pipelined memory: fixed latency lat, unaffected by the DUT reset.
  bit [15:0] mem_store [65536];
  bit        mem_written [65536];
  bit [7:0]  pv = '0;
  bit [15:0] pd [8];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return mem_written[a] ? mem_store[a] : (a ^ 16'h5A5A);
  endfunction

  always @(posedge clk) begin
    for (int i = 7; i > 0; i--) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
    pv[0] <= m_mem_en && !m_mem_wr;
    pd[0] <= mem_word(m_mem_addr);
    if (m_mem_en && m_mem_wr) begin
      mem_store[m_mem_addr]   <= m_mem_wdata;
      mem_written[m_mem_addr] <= 1'b1;
    end
  end

  assign mv      = pv[lat-1];
  assign mrd     = pd[lat-1];
  assign valid_a = mv && (sel == 0);
  assign valid_b = mv && (sel == 1);
  assign valid_c = mv && (sel == 2);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_miss(input int ch, input logic v, input logic [15:0] a);
    case (sel)
      0: begin miss_req_a[ch] = v; miss_addr_a[ch*16 +: 16] = a; end
      1: begin miss_req_b[ch] = v; miss_addr_b[ch*16 +: 16] = a; end
      default: begin miss_req_c[ch] = v; miss_addr_c[ch*16 +: 16] = a; end
    endcase
  endtask

  task automatic clr_miss(input int ch);
    case (sel)
      0: miss_req_a[ch] = 1'b0;
      1: miss_req_b[ch] = 1'b0;
      default: miss_req_c[ch] = 1'b0;
    endcase
  endtask

  // Waits for the grant of ch, then follows the whole line fill cycle by cycle.
  task automatic run_fill(input int ch, input logic [15:0] exp_base, input int bw,
                          input bit drop, input bit keep, input string nm,
                          output logic [15:0] first_word);
    int cyc, n_iss, n_rcv, bad_iss, bad_rcv, bad_oth;
    bit done_seen;
    logic [3:0] mask;
    mask = 4'(1 << ch);
    first_word = '0;
    cyc = 0;
    @(negedge clk);
    while (m_grant == 4'd0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, " grant"}, 32'(m_grant), 32'(mask));
    n_iss = 0; n_rcv = 0; bad_iss = 0; bad_rcv = 0; bad_oth = 0;
    done_seen = 1'b0; cyc = 0;
    while (1) begin
      if (drop && cyc == 0) clr_miss(ch);
      if (m_mem_en != (cyc < bw)) bad_iss++;
      if (m_mem_en) begin
        if (m_mem_wr || m_mem_addr != exp_base + 16'(2 * n_iss)) bad_iss++;
        n_iss++;
      end
      if (((m_fill_we | m_tag_we | m_done | m_wr_ack) & ~mask) != 4'd0) bad_oth++;
      if (!m_busy || m_grant != mask) bad_oth++;
      if (m_fill_we[ch]) begin
        if (m_fill_addr != exp_base + 16'(2 * n_rcv)) bad_rcv++;
        if (m_fill_data != mem_word(m_fill_addr)) bad_rcv++;
        if (m_tag_we[ch] != (n_rcv == bw - 1) || m_done[ch] != (n_rcv == bw - 1)) bad_rcv++;
        if (n_rcv == 0) first_word = m_fill_data;
        n_rcv++;
        if (m_done[ch]) done_seen = 1'b1;
      end else if (m_tag_we[ch] || m_done[ch]) begin
        bad_rcv++;
      end
      if (done_seen || cyc >= 60) break;
      @(negedge clk);
      cyc++;
    end
    if (!keep) clr_miss(ch);
    check({nm, " issue count"}, 32'(n_iss), 32'(bw));
    check({nm, " issue errors"}, 32'(bad_iss), 32'd0);
    check({nm, " strobe count"}, 32'(n_rcv), 32'(bw));
    check({nm, " strobe errors"}, 32'(bad_rcv), 32'd0);
    check({nm, " other-channel/busy errors"}, 32'(bad_oth), 32'd0);
    check({nm, " fill_done seen"}, 32'(done_seen), 32'd1);
    @(negedge clk);
    check({nm, " busy after done"}, 32'(m_busy), 32'd0);
    check({nm, " grant after done"}, 32'(m_grant), 32'd0);
  endtask

  typedef struct {
    int          ch;
    logic [15:0] addr;
    logic [15:0] exp_base;
  } fill_vec_t;

  initial begin
    fill_vec_t   tbl [4];
    logic [15:0] fw;
    int          n, cyc, nv, nwe;

    tbl[0] = '{ch: 1, addr: 16'h1236, exp_base: 16'h1230};
    tbl[1] = '{ch: 0, addr: 16'h00FF, exp_base: 16'h00F0};
    tbl[2] = '{ch: 1, addr: 16'hFFFE, exp_base: 16'hFFF0};
    tbl[3] = '{ch: 0, addr: 16'h2000, exp_base: 16'h2000};

    // Reset state, with requests pending that must not be granted yet
    sel = 0; lat = 4;
    miss_req_a = 2'b11;
    @(negedge clk);
    @(negedge clk);
    check("reset grant", 32'(grant_a), 32'd0);
    check("reset busy", 32'(busy_a), 32'd0);
    check("reset mem_enable", 32'(mem_enable_a), 32'd0);
    check("reset mem_addr", 32'(mem_addr_a), 32'd0);
    check("reset strobes", 32'({fill_we_a, fill_tag_we_a, fill_done_a, wr_ack_a}), 32'd0);
    miss_req_a = 2'b00;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      set_miss(tbl[i].ch, 1'b1, tbl[i].addr);
      run_fill(tbl[i].ch, tbl[i].exp_base, 8, 1'b0, 1'b0, $sformatf("vec%0d", i), fw);
    end

    // Simultaneous misses after reset: ch0 first, then ch1
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_miss(0, 1'b1, 16'h0A14);
    set_miss(1, 1'b1, 16'h0B2C);
    run_fill(0, 16'h0A10, 8, 1'b0, 1'b0, "both ptr0 first", fw);
    run_fill(1, 16'h0B20, 8, 1'b0, 1'b0, "both ptr0 second", fw);
    // Move the pointer to ch1 with a lone ch0 fill, then collide again
    set_miss(0, 1'b1, 16'h0500);
    run_fill(0, 16'h0500, 8, 1'b0, 1'b0, "lone ch0", fw);
    set_miss(0, 1'b1, 16'h0C00);
    set_miss(1, 1'b1, 16'h0D08);
    run_fill(1, 16'h0D00, 8, 1'b0, 1'b0, "both ptr1 first", fw);
    run_fill(0, 16'h0C00, 8, 1'b0, 1'b0, "both ptr1 second", fw);

    // Write-through with a miss to the same line: write goes first
    set_miss(1, 1'b1, 16'h0040);
    wr_req_a[1] = 1'b1; wr_addr_a[31:16] = 16'h0040; wr_data_a[31:16] = 16'hBEEF;
    @(negedge clk);
    check("write grant", 32'(grant_a), 32'h2);
    check("write mem_enable", 32'(mem_enable_a), 32'd1);
    check("write mem_wr", 32'(mem_wr_a), 32'd1);
    check("write mem_addr", 32'(mem_addr_a), 32'h0040);
    check("write mem_wdata", 32'(mem_wdata_a), 32'hBEEF);
    check("write wr_ack", 32'(wr_ack_a), 32'h2);
    check("write no fill_we", 32'(fill_we_a), 32'd0);
    wr_req_a[1] = 1'b0;
    run_fill(1, 16'h0040, 8, 1'b0, 1'b0, "refill", fw);
    check("refill word0 data", 32'(fw), 32'hBEEF);

    // Reset on the 3rd receive; late valids must be ignored
    set_miss(0, 1'b1, 16'h3000);
    n = 0; cyc = 0;
    while (n < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (fill_we_a != 2'b00) n++;
    end
    check("abort reached 3rd strobe", 32'(n), 32'd3);
    rst = 1'b1;
    clr_miss(0);
    #1;
    check("abort busy", 32'(busy_a), 32'd0);
    check("abort grant", 32'(grant_a), 32'd0);
    check("abort mem_enable", 32'(mem_enable_a), 32'd0);
    check("abort strobes now", 32'({fill_we_a, fill_done_a}), 32'd0);
    nv = 0; nwe = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b0;
      if (mv) nv++;
      if ({fill_we_a, fill_tag_we_a, fill_done_a} != 6'd0) nwe++;
    end
    check("abort late valids delivered", 32'(nv >= 3), 32'd1);
    check("abort strobes after reset", 32'(nwe), 32'd0);
    set_miss(1, 1'b1, 16'h2000);
    run_fill(1, 16'h2000, 8, 1'b0, 1'b0, "post-abort fill", fw);

    // Latency 1, 2-word lines, miss dropped right after grant
    repeat (4) @(negedge clk);
    sel = 1; lat = 1;
    set_miss(0, 1'b1, 16'h0106);
    run_fill(0, 16'h0104, 2, 1'b1, 1'b0, "drop bw2", fw);

    // Four channels all requesting: grants rotate 0,1,2,3,0
    repeat (4) @(negedge clk);
    sel = 2; lat = 2;
    for (int i = 0; i < 4; i++) set_miss(i, 1'b1, 16'((i + 1) * 16'h1000));
    for (int i = 0; i < 5; i++)
      run_fill(i % 4, 16'(((i % 4) + 1) * 16'h1000), 4, 1'b0, 1'b1, $sformatf("rr%0d", i), fw);
    for (int i = 0; i < 4; i++) clr_miss(i);
    repeat (4) @(negedge clk);
    // Top-of-memory line, 4-word geometry
    set_miss(2, 1'b1, 16'hFFFE);
    run_fill(2, 16'hFFF8, 4, 1'b0, 1'b0, "top line", fw);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
